hazard_sched_ctrl: RTL

- Pipeline hazard controller for the 5-stage CPU.
- Detects load-use hazards between ID and EX and freezes the front end while a multi-cycle multiply occupies EX.
- Sequences multi-cycle flushes after a taken branch.
- Drives the stall/flush controls consumed by the IF/ID and ID/EX pipeline registers, plus the PC write enable.

---
 rtl/hazard_sched_ctrl_if.sv | 32 +++
 rtl/hazard_sched_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_sched_ctrl_if.sv
// Pipeline-to-hazard-controller bundle: ID/EX hazard inputs and stall/flush/mult controls.
// master = pipeline datapath side, slave = hazard_sched_ctrl.
interface hazard_sched_ctrl_if #(
    parameter int unsigned ADDR_RFILE = 5
) ();
    logic                  ex_mem_r;
    logic [ADDR_RFILE-1:0] ex_addr_rt;
    logic [ADDR_RFILE-1:0] id_addr_rs;
    logic [ADDR_RFILE-1:0] id_addr_rt;
    logic                  id_uses_rt;
    logic                  id_mult;
    logic                  branch_taken;

    logic                  pc_en;
    logic                  ifid_en;
    logic                  stall_ctrl;
    logic [1:0]            stall_ctrl_ab;
    logic                  flush_ctrl;
    logic                  mult_sel;
    logic                  mult_busy;
    logic                  mult_done;

    modport master (
        output ex_mem_r, ex_addr_rt, id_addr_rs, id_addr_rt, id_uses_rt, id_mult, branch_taken,
        input  pc_en, ifid_en, stall_ctrl, stall_ctrl_ab, flush_ctrl, mult_sel, mult_busy, mult_done
    );

    modport slave (
        input  ex_mem_r, ex_addr_rt, id_addr_rs, id_addr_rt, id_uses_rt, id_mult, branch_taken,
        output pc_en, ifid_en, stall_ctrl, stall_ctrl_ab, flush_ctrl, mult_sel, mult_busy, mult_done
    );
endinterface

// File: rtl/hazard_sched_ctrl.sv
// Hazard controller for the 5-stage pipeline: load-use stall, multi-cycle mult freeze, branch flush.
// Optional HAZ_PERF_CNT_EN adds saturating stall/flush performance counters.
module hazard_sched_ctrl #(
    parameter int unsigned ADDR_RFILE = 5,
    parameter int unsigned MULT_LAT   = 4,
    parameter int unsigned FLUSH_CYC  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    hazard_sched_ctrl_if.slave   hif
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [15:0]          perf_lu_stall,
    output logic [15:0]          perf_mult_stall,
    output logic [15:0]          perf_flush
`endif
);

    localparam int unsigned MAX_LAT   = (MULT_LAT > FLUSH_CYC) ? MULT_LAT : FLUSH_CYC;
    localparam int unsigned CNT_W_RAW = $clog2(MAX_LAT);
    localparam int unsigned CNT_W     = (CNT_W_RAW < 3) ? 3 : CNT_W_RAW;
    localparam int unsigned MULT_LOAD = MULT_LAT - 2;
    localparam int unsigned FLUSH_LOAD = (FLUSH_CYC > 1) ? (FLUSH_CYC - 2) : 0;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MULT  = 2'd1,
        FLUSH = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [ADDR_RFILE-1:0] ex_rt, id_rs, id_rt;
    logic hz_rs, hz_rt, hz;

    logic       pc_en_c, ifid_en_c, stall_c, flush_c, mult_sel_c, mult_busy_c, mult_done_c;
    logic [1:0] stall_ab_c;

    assign ex_rt = hif.ex_addr_rt;
    assign id_rs = hif.id_addr_rs;
    assign id_rt = hif.id_addr_rt;

    // Load-use detection; register zero never carries a real dependency.
    assign hz_rs = hif.ex_mem_r && (ex_rt != '0) && (id_rs == ex_rt);
    assign hz_rt = hif.ex_mem_r && (ex_rt != '0) && hif.id_uses_rt && (id_rt == ex_rt);
    assign hz    = hz_rs || hz_rt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pc_en_c     = 1'b0;
        ifid_en_c   = 1'b0;
        stall_c     = 1'b0;
        stall_ab_c  = 2'b00;
        flush_c     = 1'b0;
        mult_sel_c  = 1'b0;
        mult_busy_c = 1'b0;
        mult_done_c = 1'b0;

        case (state_q)
            RUN: begin
                if (hif.branch_taken) begin
                    flush_c   = 1'b1;
                    pc_en_c   = 1'b1;
                    ifid_en_c = 1'b1;
                    if (FLUSH_CYC > 1) begin
                        state_d = FLUSH;
                        cnt_d   = CNT_W'(FLUSH_LOAD);
                    end
                end else if (hz) begin
                    stall_c    = 1'b1;
                    stall_ab_c = {hz_rs, hz_rt};
                end else if (hif.id_mult) begin
                    pc_en_c   = 1'b1;
                    ifid_en_c = 1'b1;
                    state_d   = MULT;
                    cnt_d     = CNT_W'(MULT_LOAD);
                end else begin
                    pc_en_c   = 1'b1;
                    ifid_en_c = 1'b1;
                end
            end
            MULT: begin
                mult_busy_c = 1'b1;
                mult_sel_c  = 1'b1;
                if (cnt_q == '0) begin
                    mult_done_c = 1'b1;
                    pc_en_c     = 1'b1;
                    ifid_en_c   = 1'b1;
                    state_d     = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FLUSH: begin
                // ID holds a wrong-path instruction, so hazards and new branches are masked.
                flush_c   = 1'b1;
                pc_en_c   = 1'b1;
                ifid_en_c = 1'b1;
                if (cnt_q == '0) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase

        if (rst) begin
            state_d     = RUN;
            cnt_d       = '0;
            pc_en_c     = 1'b0;
            ifid_en_c   = 1'b0;
            stall_c     = 1'b0;
            stall_ab_c  = 2'b00;
            flush_c     = 1'b0;
            mult_sel_c  = 1'b0;
            mult_busy_c = 1'b0;
            mult_done_c = 1'b0;
        end
    end

    assign hif.pc_en         = pc_en_c;
    assign hif.ifid_en       = ifid_en_c;
    assign hif.stall_ctrl    = stall_c;
    assign hif.stall_ctrl_ab = stall_ab_c;
    assign hif.flush_ctrl    = flush_c;
    assign hif.mult_sel      = mult_sel_c;
    assign hif.mult_busy     = mult_busy_c;
    assign hif.mult_done     = mult_done_c;

`ifdef HAZ_PERF_CNT_EN
    localparam int unsigned PERF_W = 16;

    logic [PERF_W-1:0] perf_lu_q, perf_lu_d;
    logic [PERF_W-1:0] perf_mult_q, perf_mult_d;
    logic [PERF_W-1:0] perf_flush_q, perf_flush_d;
    logic              lu_inc, mult_inc, flush_inc;

    assign lu_inc    = stall_c;
    assign mult_inc  = mult_busy_c && !pc_en_c;
    assign flush_inc = (state_q == RUN) && hif.branch_taken && !rst;

    // Saturating increments; each counter holds at all-ones.
    always_comb begin
        perf_lu_d    = perf_lu_q;
        perf_mult_d  = perf_mult_q;
        perf_flush_d = perf_flush_q;
        if (lu_inc && (perf_lu_q != '1)) begin
            perf_lu_d = perf_lu_q + PERF_W'(1);
        end
        if (mult_inc && (perf_mult_q != '1)) begin
            perf_mult_d = perf_mult_q + PERF_W'(1);
        end
        if (flush_inc && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + PERF_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_lu_q    <= '0;
            perf_mult_q  <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_lu_q    <= perf_lu_d;
            perf_mult_q  <= perf_mult_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_lu_stall   = perf_lu_q;
    assign perf_mult_stall = perf_mult_q;
    assign perf_flush      = perf_flush_q;
`endif

endmodule
